rf_multiport_sb: RTL and testbench
==================================

// Module: rf_multiport_sb
// PURPOSE
//  Next-generation register file for the SCP datapath: parametrised width, depth and read-port count.
//  Adds synchronous clear, optional hardwired-zero r0 and optional write-to-read bypass.
//  Adds a per-register pending scoreboard so decode can stall on multi-cycle producers.
//  Sits between decode (read/claim) and writeback (write); replaces the fixed 16x32, 2-read-port file.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  DEPTH       16  number of registers (power of 2)
//  INDEX_BITS  4   log2(DEPTH); must match DEPTH
//  NUM_RD      2   number of combinational read ports (1..4)
//  BYPASS      1   1: same-cycle write data forwarded to matching read ports
//  ZERO_REG    0   1: r0 reads as 0; writes and claims to r0 ignored
// PORTS
//  clk          in   1                    single clock, all state updates on posedge
//  reset        in   1                    synchronous, active-high
//  wrEn         in   1                    writeback enable
//  wrIndex      in   INDEX_BITS           writeback register
//  dataIn       in   DATA_WIDTH           writeback data
//  rdIndex      in   NUM_RD*INDEX_BITS    packed read indices, port i at [i*INDEX_BITS +: INDEX_BITS]
//  dataOut      out  NUM_RD*DATA_WIDTH    packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rdPending    out  NUM_RD               1: port i's register awaits an outstanding producer
//  claimEn      in   1                    decode issues an instruction that will write claimIndex
//  claimIndex   in   INDEX_BITS           register being claimed
//  busyVec      out  DEPTH                registered pending bit per register
//  sbErr        out  1                    sticky: claim hit an already-pending register
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is synchronous and active-high. At a reset posedge all
//    registers become 0, busyVec becomes 0, and sbErr becomes 0. Writes and claims in that cycle are dropped.
//  - Write: at posedge, if wrEn && !reset && !(ZERO_REG && wrIndex==0), then regs[wrIndex] <= dataIn.
//    A write also clears busyVec[wrIndex]. Writing a non-pending register is legal and leaves busyVec unchanged.
//  - Read: combinational, 0-cycle latency.
//    dataOut_i = 0 if ZERO_REG and rdIndex_i==0.
//    Otherwise, if BYPASS && wrEn && wrIndex==rdIndex_i, dataOut_i = dataIn.
//    Otherwise dataOut_i = regs[rdIndex_i].
//    With BYPASS=0, new data is visible the cycle after the write posedge.
//  - rdPending_i: busyVec[rdIndex_i], forced to 0 when any of these hold:
//    * BYPASS && wrEn && wrIndex==rdIndex_i (value forwarded this cycle)
//    * ZERO_REG && rdIndex_i==0
//  - Claim: at posedge, if claimEn && !reset && !(ZERO_REG && claimIndex==0), busyVec[claimIndex] <= 1.
//  - Claim and write to the same index in the same cycle: the claim wins, bit stays 1 (new producer).
//    The write data is still stored.
//  - sbErr: set at posedge when claimEn && busyVec[claimIndex]==1 and no same-cycle write to claimIndex.
//    Once set, it holds until reset. Only the claim is flagged; busyVec stays 1.
//  - Reset mid-operation: outstanding claims are discarded. Any later write to a cleared register is a plain write.
//  - All index arithmetic is unsigned INDEX_BITS. No wrap or out-of-range case exists since DEPTH == 2**INDEX_BITS.
// STRUCTURE
//  - Shared package rf_pkg: default DATA_WIDTH/DEPTH/INDEX_BITS constants and the index/data typedefs,
//    used by decode and writeback.
//  - Sub-module rf_pending_tracker: busyVec, claim/clear priority, sbErr.
//    Interface is clk, reset, wrEn, wrIndex, claimEn, claimIndex, busyVec, sbErr.
//  - Top: storage array, read muxes, bypass compare per port (generate loop over NUM_RD).
// TESTING
//  1. reset=1 one cycle with wrEn=1, wrIndex=3, dataIn=32'hDEAD -> next cycle all dataOut=0, busyVec=0, sbErr=0.
//  2. wrEn=1, wrIndex=5, dataIn=32'h1234, rdIndex port0=5, BYPASS=1 -> dataOut0=32'h1234 same cycle.
//     With BYPASS=0: old value (0) that cycle, 32'h1234 next cycle.
//  3. ZERO_REG=1: write r0=32'hFFFF_FFFF, claim r0 -> dataOut for r0 = 0, busyVec[0]=0, sbErr=0.
//  4. claim r7 -> busyVec[7]=1, rdPending for r7 =1.
//     Next cycle write r7=32'hA5 -> rdPending=0 that cycle (BYPASS=1), busyVec[7]=0 after posedge.
//  5. busyVec[2]=1, same cycle claim r2 and write r2=32'h55 -> busyVec[2] stays 1, regs[2]=32'h55, sbErr=0.
//  6. busyVec[9]=1, claim r9 with no write -> sbErr=1 after posedge, holds until reset.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and index/data types for decode and writeback.
// Holds the default geometry of the SCP register file (32-bit x 16 entries, 2 read ports).
// No ports; imported by rf_multiport_sb and rf_pending_tracker.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_DEPTH      = 16;
    localparam int RF_INDEX_BITS = 4;
    localparam int RF_NUM_RD     = 2;

    typedef logic [RF_INDEX_BITS-1:0] rf_index_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_pending_tracker.sv
// Per-register pending scoreboard: decode claims set a bit, writeback clears it.
// Ports: clk/reset (sync, active-high), write (wrEn/wrIndex), claim (claimEn/claimIndex),
//        busyVec (registered pending bits), sbErr (sticky double-claim flag).
module rf_pending_tracker
    import rf_pkg::*;
#(
    parameter int DEPTH      = RF_DEPTH,
    parameter int INDEX_BITS = RF_INDEX_BITS,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [INDEX_BITS-1:0] wrIndex,
    input  logic                  claimEn,
    input  logic [INDEX_BITS-1:0] claimIndex,
    output logic [DEPTH-1:0]      busyVec,
    output logic                  sbErr
);

    logic             wr_ok;
    logic             claim_ok;
    logic             same_idx_wr;
    logic             double_claim;
    logic [DEPTH-1:0] busy_nxt;

    // r0 is never tracked when it is hardwired to zero.
    assign wr_ok    = wrEn    && !((ZERO_REG != 0) && (wrIndex    == '0));
    assign claim_ok = claimEn && !((ZERO_REG != 0) && (claimIndex == '0));

    // A write landing on the claimed register in the same cycle retires the
    // old producer, so re-claiming it is legitimate and not an error.
    assign same_idx_wr  = wrEn && (wrIndex == claimIndex);
    assign double_claim = claim_ok && busyVec[claimIndex] && !same_idx_wr;

    // Clear first, then set: a same-cycle claim to the written index wins.
    always_comb begin
        busy_nxt = busyVec;
        if (wr_ok) begin
            busy_nxt[wrIndex] = 1'b0;
        end
        if (claim_ok) begin
            busy_nxt[claimIndex] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busyVec <= '0;
            sbErr   <= 1'b0;
        end else begin
            busyVec <= busy_nxt;
            if (double_claim) begin
                sbErr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-read-port register file with optional hardwired r0, write bypass and pending scoreboard.
// Ports: clk/reset (sync, active-high); write (wrEn/wrIndex/dataIn); packed reads (rdIndex -> dataOut,
//        rdPending, 0-cycle); claim (claimEn/claimIndex); busyVec and sticky sbErr from the tracker.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int INDEX_BITS = RF_INDEX_BITS,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wrEn,
    input  logic [INDEX_BITS-1:0]        wrIndex,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    input  logic [NUM_RD*INDEX_BITS-1:0] rdIndex,
    output logic [NUM_RD*DATA_WIDTH-1:0] dataOut,
    output logic [NUM_RD-1:0]            rdPending,
    input  logic                         claimEn,
    input  logic [INDEX_BITS-1:0]        claimIndex,
    output logic [DEPTH-1:0]             busyVec,
    output logic                         sbErr
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_ok;

    assign wr_ok = wrEn && !((ZERO_REG != 0) && (wrIndex == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wrIndex] <= dataIn;
        end
    end

    rf_pending_tracker #(
        .DEPTH      (DEPTH),
        .INDEX_BITS (INDEX_BITS),
        .ZERO_REG   (ZERO_REG)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .wrEn       (wrEn),
        .wrIndex    (wrIndex),
        .claimEn    (claimEn),
        .claimIndex (claimIndex),
        .busyVec    (busyVec),
        .sbErr      (sbErr)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [INDEX_BITS-1:0] idx;
        logic                  zero_hit;
        logic                  byp_hit;

        assign idx      = rdIndex[i*INDEX_BITS +: INDEX_BITS];
        assign zero_hit = (ZERO_REG != 0) && (idx == '0);
        assign byp_hit  = (BYPASS != 0) && wrEn && (wrIndex == idx);

        // r0 override beats the bypass so a write to r0 can never leak out.
        assign dataOut[i*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 :
                                                     byp_hit  ? dataIn : regs[idx];

        // A forwarded value satisfies the consumer, so it must not stall.
        assign rdPending[i] = busyVec[idx] && !zero_hit && !byp_hit;
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Testbench for rf_multiport_sb: two instances (bypass/no-zero and no-bypass/zero-r0)
// share one stimulus stream and are compared every cycle against an array-based model,
// plus directed scenarios with fixed expected constants.
module tb_rf_multiport_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn;
    logic [3:0]  wrIndex;
    logic [31:0] dataIn;
    logic [7:0]  rdIndex;
    logic        claimEn;
    logic [3:0]  claimIndex;

    logic [63:0] data_out_a, data_out_b;
    logic [1:0]  pend_a, pend_b;
    logic [15:0] busy_a, busy_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 = instance a, index 1 = instance b.
    logic [31:0] m_regs [2][16];
    bit          m_busy [2][16];
    bit          m_err  [2];
    bit          m_bp   [2];
    bit          m_zr   [2];

    always #5 clk = ~clk;

    rf_multiport_sb #(.BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrIndex(wrIndex), .dataIn(dataIn),
        .rdIndex(rdIndex), .dataOut(data_out_a), .rdPending(pend_a),
        .claimEn(claimEn), .claimIndex(claimIndex), .busyVec(busy_a), .sbErr(err_a)
    );

    rf_multiport_sb #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrIndex(wrIndex), .dataIn(dataIn),
        .rdIndex(rdIndex), .dataOut(data_out_b), .rdPending(pend_b),
        .claimEn(claimEn), .claimIndex(claimIndex), .busyVec(busy_b), .sbErr(err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [3:0] wi,
                         input logic [31:0] di, input logic [3:0] r0, input logic [3:0] r1,
                         input logic ce, input logic [3:0] ci);
        @(negedge clk);
        reset = rst; wrEn = we; wrIndex = wi; dataIn = di;
        rdIndex = {r1, r0}; claimEn = ce; claimIndex = ci;
        #2;
    endtask

    task automatic idle(input logic [3:0] r0, input logic [3:0] r1);
        drive(1'b0, 1'b0, 4'd0, 32'd0, r0, r1, 1'b0, 4'd0);
    endtask

    // Compare every output of both instances against the model's view of this cycle.
    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] exp_busy;
            for (int r = 0; r < 16; r++) exp_busy[r] = m_busy[k][r];
            check($sformatf("busy%0d", k), k == 0 ? busy_a : busy_b, exp_busy);
            check($sformatf("err%0d", k), k == 0 ? err_a : err_b, m_err[k]);
            for (int p = 0; p < 2; p++) begin
                logic [3:0]  idx;
                logic [31:0] exp_d;
                logic        exp_p;
                logic        fwd;
                idx   = rdIndex[p*4 +: 4];
                fwd   = m_bp[k] && wrEn && (wrIndex == idx);
                if (m_zr[k] && idx == 0)  exp_d = 32'd0;
                else if (fwd)             exp_d = dataIn;
                else                      exp_d = m_regs[k][idx];
                exp_p = m_busy[k][idx] && !fwd && !(m_zr[k] && idx == 0);
                check($sformatf("data%0d.%0d", k, p),
                      k == 0 ? data_out_a[p*32 +: 32] : data_out_b[p*32 +: 32], exp_d);
                check($sformatf("pend%0d.%0d", k, p), k == 0 ? pend_a[p] : pend_b[p], exp_p);
            end
        end
    endtask

    // Advance one clock and apply the register-file rules to the model.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 16; r++) begin
                    m_regs[k][r] = 32'd0;
                    m_busy[k][r] = 1'b0;
                end
                m_err[k] = 1'b0;
            end else begin
                bit wr_ok, cl_ok;
                wr_ok = wrEn    && !(m_zr[k] && wrIndex == 0);
                cl_ok = claimEn && !(m_zr[k] && claimIndex == 0);
                if (cl_ok && m_busy[k][claimIndex] && !(wrEn && wrIndex == claimIndex))
                    m_err[k] = 1'b1;
                if (wr_ok) begin
                    m_regs[k][wrIndex] = dataIn;
                    m_busy[k][wrIndex] = 1'b0;
                end
                if (cl_ok) m_busy[k][claimIndex] = 1'b1;
            end
        end
    endtask

    initial begin
        m_bp[0] = 1'b1; m_zr[0] = 1'b0;
        m_bp[1] = 1'b0; m_zr[1] = 1'b1;
        reset = 1'b1; wrEn = 1'b0; wrIndex = '0; dataIn = '0;
        rdIndex = '0; claimEn = 1'b0; claimIndex = '0;

        // 1: reset drops a concurrent write
        drive(1'b1, 1'b1, 4'd3, 32'hDEAD, 4'd3, 4'd0, 1'b0, 4'd0);
        tick();
        idle(4'd3, 4'd0);
        check_model();
        check("rst_data_a", data_out_a, 64'd0);
        check("rst_data_b", data_out_b, 64'd0);
        check("rst_busy", {busy_a, busy_b}, 32'd0);
        check("rst_err", {err_a, err_b}, 2'b00);
        tick();

        // 2: bypass vs. no-bypass visibility
        drive(1'b0, 1'b1, 4'd5, 32'h1234, 4'd5, 4'd1, 1'b0, 4'd0);
        check_model();
        check("byp_same_cycle", data_out_a[31:0], 32'h1234);
        check("nobyp_same_cycle", data_out_b[31:0], 32'h0);
        tick();
        idle(4'd5, 4'd1);
        check_model();
        check("nobyp_next_cycle", data_out_b[31:0], 32'h1234);
        tick();

        // 3: hardwired r0 ignores writes and claims
        drive(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 4'd5, 1'b1, 4'd0);
        check_model();
        tick();
        idle(4'd0, 4'd5);
        check_model();
        check("zr_data", data_out_b[31:0], 32'h0);
        check("zr_busy0", busy_b[0], 1'b0);
        check("zr_err", err_b, 1'b0);
        tick();

        // 4: claim then retire r7
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd7, 4'd0, 1'b1, 4'd7);
        check_model();
        tick();
        idle(4'd7, 4'd0);
        check_model();
        check("claim_busy7", busy_a[7], 1'b1);
        check("claim_pend", pend_a[0], 1'b1);
        tick();
        drive(1'b0, 1'b1, 4'd7, 32'hA5, 4'd7, 4'd0, 1'b0, 4'd0);
        check_model();
        check("retire_pend_byp", pend_a[0], 1'b0);
        check("retire_pend_nobyp", pend_b[0], 1'b1);
        tick();
        idle(4'd7, 4'd0);
        check_model();
        check("retire_busy7", busy_a[7], 1'b0);
        tick();

        // 5: same-cycle claim and write to a pending register
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd2, 1'b1, 4'd2);
        tick();
        drive(1'b0, 1'b1, 4'd2, 32'h55, 4'd0, 4'd2, 1'b1, 4'd2);
        check_model();
        tick();
        idle(4'd0, 4'd2);
        check_model();
        check("cw_busy2", busy_a[2], 1'b1);
        check("cw_data2", data_out_a[63:32], 32'h55);
        check("cw_err", err_a, 1'b0);
        tick();

        // 6: double claim sets a sticky error until reset
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd9, 4'd2, 1'b1, 4'd9);
        tick();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd9, 4'd2, 1'b1, 4'd9);
        check_model();
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(4'd9, 4'd2);
            check_model();
            check("err_sticky", {err_a, err_b}, 2'b11);
            tick();
        end
        drive(1'b1, 1'b0, 4'd0, 32'd0, 4'd9, 4'd2, 1'b0, 4'd0);
        tick();
        idle(4'd9, 4'd2);
        check_model();
        check("err_cleared", {err_a, err_b}, 2'b00);
        tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
